// File: rtl/bin_bcd_conv.sv
// Sequential binary <-> packed-BCD converter.
// Mode 0 runs shift-and-add-3 (double dabble) and mode 1 runs shift-and-subtract-3
// (reverse dabble). Both modes take W shift cycles plus one DONE cycle.
module bin_bcd_conv #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  err
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = BW + W;
  localparam int unsigned CW = (W < 2) ? 1 : $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [SW-1:0]   scr_q;      // {bcd field, binary field}
  logic [SW-1:0]   scr_step;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;
  logic            invalid_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   out_data_q;
  logic            err_q;
  logic            in_digit_bad;
  logic [BW-1:0]   bin_ext;

  // Flag any packed input digit above 9.
  always_comb begin
    in_digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_data[4*i +: 4] > 4'd9) in_digit_bad = 1'b1;
    end
  end

  // One dabble step on the scratch register; digit arithmetic wraps modulo 16.
  always_comb begin
    scr_step = scr_q;
    if (!mode_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (scr_step[W+4*i +: 4] >= 4'd5) scr_step[W+4*i +: 4] = scr_step[W+4*i +: 4] + 4'd3;
      end
      scr_step = scr_step << 1;
    end else begin
      scr_step = scr_step >> 1;
      for (int i = 0; i < DIGITS; i++) begin
        if (scr_step[W+4*i +: 4] >= 4'd8) scr_step[W+4*i +: 4] = scr_step[W+4*i +: 4] - 4'd3;
      end
    end
  end

  // Binary field of the final step, zero-extended to the output width.
  always_comb begin
    bin_ext        = '0;
    bin_ext[W-1:0] = scr_step[W-1:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      scr_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      invalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q    <= mode;
            invalid_q <= mode & in_digit_bad;
            // Operand goes straight into the field it is consumed from; the other field is cleared.
            scr_q     <= mode ? {in_data, {W{1'b0}}} : {{BW{1'b0}}, in_data[W-1:0]};
            cnt_q     <= CW'(W);
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          scr_q <= scr_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            out_data_q <= mode_q ? bin_ext : scr_step[SW-1:W];
            // Leftover BCD after W right shifts means the value did not fit in W bits.
            err_q      <= mode_q & (invalid_q | (|scr_step[SW-1:W]));
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_data_q;
  assign err      = err_q;

endmodule
